// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encoding and the add/subtract operation select values.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_full_add1.sv
// Single 1-bit full-adder cell. It is the only arithmetic in the block and
// is reused by the controller once per bit position.
module full_add1 (
  input  logic A,
  input  logic B,
  input  logic cin,
  output logic Sum,
  output logic cout
);

  // Plain full-adder sum and carry equations.
  always_comb begin
    Sum  = A ^ B ^ cin;
    cout = (A & B) | (A & cin) | (B & cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller. Operands are captured on the
// accepting edge, then one bit per clock (LSB first) is pushed through a
// single full_add1 cell with the carry kept in a register.
//
// Handshake: ready is high only in IDLE; an edge with ready=1 and start=1
// accepts the operands. done is a one-cycle pulse in DONE, during which
// Sum/Cout/Overflow are valid; they hold until the next accepted start.
// start seen outside IDLE is dropped, never queued.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_sum, fa_cout;

  // Operands are shifted right each bit, so bit 0 is always the current bit.
  full_add1 u_fa (
    .A   (a_q[0]),
    .B   (b_q[0]),
    .cin (carry_q),
    .Sum (fa_sum),
    .cout(fa_cout)
  );

  // State and datapath registers; reset zeroes everything and returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtract is A + ~B + 1: invert B and force the carry-in to 1.
          a_d     = A;
          b_d     = (sub == OP_SUB) ? ~B : B;
          carry_d = (sub == OP_SUB) ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[cnt_q] = fa_sum;
        carry_d      = fa_cout;
        a_d          = a_q >> 1;
        b_d          = b_q >> 1;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ fa_cout;
          cout_d  = fa_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed vector table, randomized operations
// against an arithmetic reference model, and multi-cycle corner sequences
// (start during an operation, reset mid-operation, reset with start).
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic         ready;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Overflow;
  state_t       dbg_state;

  int n_vec;
  int n_err;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[6];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .A        (A),
    .B        (B),
    .cin      (cin),
    .ready    (ready),
    .done     (done),
    .Sum      (Sum),
    .Cout     (Cout),
    .Overflow (Overflow),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain unsigned/signed integer arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, output logic [W-1:0] r_sum,
                       output logic r_cout, output logic r_ovf);
    int ua, ub, sa, sb, ut, st;
    int smin, smax;
    ua   = int'(a);
    ub   = int'(b);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    smin = -(1 << (W - 1));
    smax = (1 << (W - 1)) - 1;
    if (s) begin
      ut     = ua - ub;
      st     = sa - sb;
      r_cout = (ua >= ub);
    end else begin
      ut     = ua + ub + int'(c);
      st     = sa + sb + int'(c);
      r_cout = (ut >= (1 << W));
    end
    r_sum = ut[W-1:0];
    r_ovf = (st < smin) || (st > smax);
  endtask

  // Driver: wait for ready (bounded), drive one op for a single edge.
  task automatic accept_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c);
    int k;
    k = 0;
    while (!ready && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("ready_before_start", 32'(ready), 32'd1);
    sub   = s;
    A     = a;
    B     = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    cin   = 1'($urandom);
    sub   = 1'($urandom);
  endtask

  // Wait for done after an accept; returns edge count (0 on timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Full operation with result and handshake checks against the model.
  task automatic run_op(input string name, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c);
    logic [W-1:0] e_sum;
    logic         e_cout, e_ovf;
    int           lat;
    model(a, b, c, s, e_sum, e_cout, e_ovf);
    accept_op(s, a, b, c);
    check({name, "_ready_low"}, 32'(ready), 32'd0);
    wait_done(lat);
    check({name, "_latency"}, 32'(lat), 32'(W));
    check({name, "_sum"}, 32'(Sum), 32'(e_sum));
    check({name, "_cout"}, 32'(Cout), 32'(e_cout));
    check({name, "_ovf"}, 32'(Overflow), 32'(e_ovf));
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    check({name, "_ready_after"}, 32'(ready), 32'd1);
    check({name, "_sum_hold"}, 32'(Sum), 32'(e_sum));
  endtask

  initial begin
    int           lat;
    logic [W-1:0] e_sum;
    logic         e_cout, e_ovf;

    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    A     = '0;
    B     = '0;
    cin   = 1'b0;

    vecs[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(Sum), 32'd0);
    check("reset_cout", 32'(Cout), 32'd0);
    check("reset_ovf", 32'(Overflow), 32'd0);

    // Directed table with hand-computed expectations.
    for (int i = 0; i < 6; i++) begin
      accept_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
      check($sformatf("vec%0d_sum", i), 32'(Sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 32'(Cout), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_ovf", i), 32'(Overflow), 32'(vecs[i].exp_ovf));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_low", i), 32'(done), 32'd0);
    end

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 1'($urandom_range(1, 0)), W'($urandom),
             W'($urandom), 1'($urandom_range(1, 0)));
    end

    // start pulses during RUN and during DONE are ignored.
    model(8'h3C, 8'h5A, 1'b1, 1'b0, e_sum, e_cout, e_ovf);
    accept_op(1'b0, 8'h3C, 8'h5A, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done && lat == 0) lat = k;
      if (k == 2 || k == 8) begin
        start = 1'b1;
        sub   = 1'b1;
        A     = 8'hAA;
        B     = 8'h11;
      end else begin
        start = 1'b0;
      end
      if (k == 8) break;
    end
    check("ign_latency", 32'(lat), 32'(W));
    check("ign_sum", 32'(Sum), 32'(e_sum));
    check("ign_cout", 32'(Cout), 32'(e_cout));
    check("ign_ovf", 32'(Overflow), 32'(e_ovf));
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_ready_after_done", 32'(ready), 32'd1);
    check("ign_done_low", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("ign_not_queued", 32'(ready), 32'd1);
    check("ign_sum_hold", 32'(Sum), 32'(e_sum));

    // Reset during RUN aborts with no done pulse.
    accept_op(1'b0, 8'hFF, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_sum", 32'(Sum), 32'd0);
    check("abort_cout", 32'(Cout), 32'd0);
    check("abort_ovf", 32'(Overflow), 32'd0);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (done) lat = k;
    end
    check("abort_no_done", 32'(lat), 32'd0);
    run_op("after_abort", 1'b0, 8'h0F, 8'h01, 1'b0);

    // Reset and start on the same edge: reset wins.
    sub   = 1'b0;
    A     = 8'h12;
    B     = 8'h34;
    start = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    check("rst_start_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    check("rst_start_idle", 32'(ready), 32'd1);
    check("rst_start_sum", 32'(Sum), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
